// File: rtl/mux_scan_sequencer.sv
// mux_scan_sequencer: steps a 16x1 mux through all selects, samples its output
// and compares the reassembled word against the word driven onto the mux.
module mux_scan_sequencer #(
    parameter int DWELL = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [15:0] word_in,
    output logic [15:0] mux_data,
    output logic [3:0]  mux_sel,
    input  logic        mux_y,
    output logic        busy,
    output logic [15:0] word_out,
    output logic        done,
    output logic        match
);
    if (DWELL < 1 || DWELL > 255) begin : g_bad_dwell
        $error("DWELL must be within 1..255");
    end

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
    state_t      state;
    logic [7:0]  cnt;
    logic [15:0] shadow, shadow_nxt;
    logic        last;

    // Fold the current sample in so the final bit reaches word_out on the same edge.
    always_comb begin
        shadow_nxt = shadow;
        shadow_nxt[mux_sel] = mux_y;
    end
    assign last = cnt == 8'(DWELL - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            mux_data <= '0;
            mux_sel  <= '0;
            busy     <= 1'b0;
            word_out <= '0;
            done     <= 1'b0;
            match    <= 1'b0;
            cnt      <= '0;
            shadow   <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    mux_data <= word_in;
                    mux_sel  <= '0;
                    cnt      <= '0;
                    shadow   <= '0;
                    busy     <= 1'b1;
                    state    <= SCAN;
                end
                SCAN: if (abort) begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end else if (last) begin
                    shadow <= shadow_nxt;
                    cnt    <= '0;
                    if (mux_sel == 4'd15) begin
                        word_out <= shadow_nxt;
                        match    <= shadow_nxt == mux_data;
                        done     <= 1'b1;
                        state    <= DONE;
                    end else begin
                        mux_sel <= mux_sel + 4'd1;
                    end
                end else begin
                    cnt <= cnt + 8'd1;
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/mux_scan_sequencer.md
# mux_scan_sequencer

Sequencer that drives the 16x1 multiplexer (`mux16x1`) in the hierarchical-structural lab.
- Accepts a 16-bit word and presents it on the mux data bus.
- Steps the mux select 0..15, dwelling a programmable number of cycles on each value.
- Samples the mux output bit at the end of each dwell and reassembles the bits into a word.
- Reports completion and whether the reassembled word matches the word that was loaded, so the mux is checked in-circuit without a bench-side monitor.

## Interface
Parameters:
- `DWELL`, default 1: clock cycles each select value is held. Legal range 1..255; any other value is an elaboration error.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a scan; sampled only in IDLE.
- `abort`  in  1  synchronous cancel of a scan in progress.
- `word_in`  in  16  word to drive onto the mux; captured when `start` is accepted.
- `mux_data`  out  16  registered copy of `word_in`; connects to mux `i`.
- `mux_sel`  out  4  registered select; connects to mux `select`.
- `mux_y`  in  1  mux output `y`.
- `busy`  out  1  high in SCAN and DONE.
- `word_out`  out  16  reassembled word, bit n = `mux_y` sampled while `mux_sel` = n.
- `done`  out  1  one-cycle completion pulse.
- `match`  out  1  `word_out` == `mux_data`; valid from `done`, held until the next `done`.

## Operation
- States: IDLE, SCAN, DONE. Reset state is IDLE.
- Reset values: `mux_data` = 0, `mux_sel` = 0, `busy` = 0, `word_out` = 0, `done` = 0, `match` = 0, dwell counter = 0, shadow register = 0.

IDLE
- `start` = 1 at a rising edge causes, at that edge:
  - `mux_data` <= `word_in`
  - `mux_sel` <= 0
  - dwell counter <= 0
  - shadow register <= 0
  - transition to SCAN

SCAN
- Each cycle the dwell counter increments.
- When the counter = `DWELL`-1:
  - shadow[`mux_sel`] <= `mux_y`
  - counter <= 0
  - if `mux_sel` = 15, go to DONE; otherwise `mux_sel` <= `mux_sel` + 1.
- `mux_sel` does not wrap within a scan. It holds at 15 through DONE and returns to 0 on the next accepted `start`.

DONE (one cycle)
- `done` = 1.
- `word_out` <= shadow register.
- `match` <= (shadow register == `mux_data`).
- Return to IDLE.

General rules
- `word_out` and `match` change only on the DONE transition. Partial results are never visible.
- `start` outside IDLE is ignored; it is not queued.
- `abort` = 1 in SCAN:
  - return to IDLE at the next edge
  - no `done` pulse
  - `word_out` and `match` keep their previous values
  - `mux_data` is held
- `abort` has no effect in IDLE or DONE. If `abort` and the final sample coincide, abort wins.
- `start` and `abort` both high in IDLE: `start` is accepted.
- Asynchronous reset at any time forces all reset values immediately. There is no resume after reset.

## Timing
- Start accepted at edge E0.
- `mux_sel` = n during cycles E0 + n·`DWELL` .. E0 + (n+1)·`DWELL` − 1.
- `mux_y` is sampled at the last edge of each dwell. With `DWELL` = 1, sample and select increment occur at the same edge; the mux path is combinational and must settle within one cycle.
- `done` is high for the single cycle after edge E0 + 16·`DWELL`.
- Start-to-done latency: 16·`DWELL` + 1 cycles.
- `busy` rises at E0 and falls when DONE exits.
- Earliest next `start` acceptance: the edge ending the first IDLE cycle after `done`, i.e. minimum period 16·`DWELL` + 2 cycles.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- Reset: assert `rst_n` = 0 mid-scan at `mux_sel` = 6 -> all outputs go to 0 without waiting for a clock edge; after release, `start` with 16'h0F0F scans correctly and `match` = 1.
- Nominal: `DWELL` = 1, real `mux16x1` connected, `word_in` = 16'hAAAA -> `mux_sel` counts 0..15 on consecutive cycles, `done` 17 cycles after start, `word_out` = 16'hAAAA, `match` = 1.
- Dwell: `DWELL` = 3, `word_in` = 16'h1234 -> each select value held exactly 3 cycles, `done` 49 cycles after start, `word_out` = 16'h1234, `match` = 1.
- Fault injection: `word_in` = 16'h0000, bench forces `mux_y` = 1 while `mux_sel` = 5 -> `word_out` = 16'h0020, `match` = 0.
- Handshake: re-pulse `start` with 16'hFFFF at `mux_sel` = 4 during a 16'h5555 scan -> ignored; result 16'h5555, `match` = 1. Then start 16'h00FF and assert `abort` at `mux_sel` = 7 -> IDLE next edge, no `done`, `word_out` stays 16'h5555.
- Back-to-back: start 16'hC3C3 in the first IDLE cycle after `done` -> accepted; second `done` exactly 16·`DWELL` + 2 cycles after the first, `word_out` = 16'hC3C3.
